// File: rtl/muskoka_reset_ctrl.sv
// muskoka_reset_ctrl
//   Reset sequencer feeding the muskoka SoC active-high rst_i. The SoC is held
//   in reset until the synchronized clock-lock has been seen and a hold
//   interval has elapsed. Lock loss, software requests and (optionally) a
//   watchdog trigger warm resets. The last cause and a saturating warm-reset
//   count are exported.
//
//   Optional feature: define MUSKOKA_RESET_WDT_EN to build the watchdog.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   lock_i      clock-lock indication (asynchronous, synchronized here)
//   sw_rst_i    software reset request (synchronous)
//   wdt_kick_i  watchdog kick (synchronous; unused without the watchdog)
//   rst_o       active-high reset to the SoC
//   ready_o     high while the SoC is out of reset
//   cause_o     last reset cause: 00 external, 01 lock loss, 10 software,
//               11 watchdog
//   rst_cnt_o   saturating count of warm resets
module muskoka_reset_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned WDT_CYCLES  = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       lock_i,
  input  logic       sw_rst_i,
  input  logic       wdt_kick_i,
  output logic       rst_o,
  output logic       ready_o,
  output logic [1:0] cause_o,
  output logic [7:0] rst_cnt_o
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  typedef enum logic [1:0] {
    S_ASSERT,
    S_HOLD,
    S_RUN
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [1:0]             cause_n;
  logic [7:0]             rst_cnt_n;
  logic                   rst_n_val, ready_n_val;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_sync;
  logic                   wdt_expire;
  logic                   warm;

  // Lock synchronizer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], lock_i};
    end
  end

  assign lock_sync = sync[SYNC_STAGES-1];

`ifdef MUSKOKA_RESET_WDT_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt;

  assign wdt_expire = (state == S_RUN) && (wdt == WDT_LAST) && !wdt_kick_i;

  // Counter runs only while staying in S_RUN; any exit (including its own
  // expiry) clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdt <= '0;
    end else if (state_n != S_RUN || state != S_RUN || wdt_kick_i) begin
      wdt <= '0;
    end else begin
      wdt <= wdt + WW'(1);
    end
  end
`else
  localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
  logic unused_kick;

  assign unused_kick = wdt_kick_i;
  assign wdt_expire  = 1'b0;
`endif

  // Next-state and next-output logic; outputs are registered from the
  // next-state decision so they change on the same edge as the state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cause_n   = cause_o;
    rst_cnt_n = rst_cnt_o;
    warm      = 1'b0;

    case (state)
      S_ASSERT: begin
        if (lock_sync) begin
          state_n = S_HOLD;
          cnt_n   = '0;
        end
      end
      S_HOLD: begin
        cnt_n = cnt + CW'(1);
        if (!lock_sync) begin
          state_n = S_ASSERT;
          cause_n = CAUSE_LOCK;
          warm    = 1'b1;
        end else if (sw_rst_i) begin
          cnt_n   = '0;
          cause_n = CAUSE_SW;
          warm    = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_sync) begin
          state_n = S_ASSERT;
          cause_n = CAUSE_LOCK;
          warm    = 1'b1;
        end else if (wdt_expire) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          cause_n = CAUSE_WDT;
          warm    = 1'b1;
        end else if (sw_rst_i) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          cause_n = CAUSE_SW;
          warm    = 1'b1;
        end
      end
      default: begin
        state_n = S_ASSERT;
        cnt_n   = '0;
      end
    endcase

    if (warm && rst_cnt_o != 8'hFF) begin
      rst_cnt_n = rst_cnt_o + 8'd1;
    end

    rst_n_val   = (state_n != S_RUN);
    ready_n_val = (state_n == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_ASSERT;
      cnt       <= '0;
      rst_o     <= 1'b1;
      ready_o   <= 1'b0;
      cause_o   <= CAUSE_EXT;
      rst_cnt_o <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rst_o     <= rst_n_val;
      ready_o   <= ready_n_val;
      cause_o   <= cause_n;
      rst_cnt_o <= rst_cnt_n;
    end
  end

endmodule
